mr_pctr_ctrl: RTL and testbench

MR_PCTR_CTRL -- requirements
Module: mr_pctr_ctrl

---
 rtl/mr_pctr_ctrl.sv | 152 +++++++++++++++
 tb/tb_mr_pctr_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mr_pctr_ctrl.sv
// APB control front-end for a performance-counter bank: enable/window/freeze
// control, sticky status with interrupt, and one-wait-state counter readback.
module mr_pctr_ctrl #(
    parameter int NUM_CTRS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        ctr_en,
    output logic        ctr_clr,
    input  logic        ctr_sat,
    output logic        ctr_rd_req,
    output logic [6:0]  ctr_rd_idx,
    input  logic [31:0] ctr_rd_data,
    output logic        irq
);

    typedef enum logic {
        S_IDLE,
        S_RD_WAIT
    } state_t;

    localparam logic [11:0] CTR_BASE = 12'h100;
    localparam logic [9:0]  CTR_LAST = 10'(NUM_CTRS);

    state_t      state, state_nxt;
    logic        fos, irq_en, sat_stop, win_done;
    logic [31:0] window, wrem;
    logic [6:0]  idx_q;
    logic [11:0] ctr_off;
    logic [31:0] reg_rd;
    logic        is_ctr, access, wr_en, rd_start;
    logic        ctrl_wr, status_wr, window_wr;
    logic        en_rise, expire, sat_hit, en_nxt, wrem_load;

    // Counter i lives at CTR_BASE + 4*i; i == NUM_CTRS is the cycle counter.
    assign ctr_off = paddr - CTR_BASE;
    assign is_ctr  = (paddr >= CTR_BASE) && (ctr_off[1:0] == 2'b00) &&
                     (ctr_off[11:2] <= CTR_LAST);

    // Gating with reset keeps pready/prdata/ctr_rd_req at idle values while reset is held.
    assign access    = reset & psel & penable;
    assign wr_en     = access & pwrite & (state == S_IDLE);
    assign ctrl_wr   = wr_en && (paddr == 12'h000);
    assign status_wr = wr_en && (paddr == 12'h004);
    assign window_wr = wr_en && (paddr == 12'h008);

    assign expire    = ctr_en && (window != 32'd0) && (wrem == 32'd1);
    assign sat_hit   = ctr_en && fos && ctr_sat;
    assign en_rise   = ctrl_wr && !ctr_en && pwdata[0];
    assign wrem_load = (ctrl_wr && pwdata[8]) || en_rise;

    assign irq = irq_en & (sat_stop | win_done);

    always_comb begin
        reg_rd = 32'd0;
        case (paddr)
            12'h000: reg_rd = {29'd0, irq_en, fos, ctr_en};
            12'h004: reg_rd = {29'd0, win_done, sat_stop, ctr_en};
            12'h008: reg_rd = window;
            12'h00C: reg_rd = wrem;
            default: reg_rd = 32'd0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        rd_start   = 1'b0;
        pready     = 1'b1;
        prdata     = 32'd0;
        ctr_rd_req = 1'b0;
        ctr_rd_idx = idx_q;
        case (state)
            S_IDLE: begin
                if (access && !pwrite) begin
                    if (is_ctr) begin
                        rd_start   = 1'b1;
                        ctr_rd_req = 1'b1;
                        ctr_rd_idx = ctr_off[8:2];
                        pready     = 1'b0;
                        state_nxt  = S_RD_WAIT;
                    end else begin
                        prdata = reg_rd;
                    end
                end
            end
            S_RD_WAIT: begin
                prdata    = ctr_rd_data;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Hardware stop (expiry or saturation freeze) overrides a same-cycle EN write.
    always_comb begin
        en_nxt = ctr_en;
        if (ctrl_wr)
            en_nxt = pwdata[0];
        if (expire || sat_hit)
            en_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx_q    <= 7'd0;
            ctr_en   <= 1'b0;
            ctr_clr  <= 1'b0;
            fos      <= 1'b0;
            irq_en   <= 1'b0;
            sat_stop <= 1'b0;
            win_done <= 1'b0;
            window   <= 32'd0;
            wrem     <= 32'd0;
        end else begin
            state   <= state_nxt;
            ctr_en  <= en_nxt;
            ctr_clr <= ctrl_wr & pwdata[8];
            if (rd_start)
                idx_q <= ctr_off[8:2];
            if (ctrl_wr) begin
                fos    <= pwdata[1];
                irq_en <= pwdata[2];
            end
            if (window_wr)
                window <= pwdata;
            if (wrem_load)
                wrem <= window;
            else if (expire)
                wrem <= 32'd0;
            else if (ctr_en && (window != 32'd0) && (wrem != 32'd0))
                wrem <= wrem - 32'd1;
            // Sticky status: a hardware set beats a same-cycle write-one-to-clear.
            if (sat_hit)
                sat_stop <= 1'b1;
            else if (status_wr && pwdata[1])
                sat_stop <= 1'b0;
            if (expire)
                win_done <= 1'b1;
            else if (status_wr && pwdata[2])
                win_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mr_pctr_ctrl.sv
// Directed bench for mr_pctr_ctrl: register access, window expiry, saturation
// freeze, counter readback timing, simultaneity and reset during a read.
module tb_mr_pctr_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = 12'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata;
    logic        pready;
    logic        ctr_en;
    logic        ctr_clr;
    logic        ctr_sat = 1'b0;
    logic        ctr_rd_req;
    logic [6:0]  ctr_rd_idx;
    logic [31:0] ctr_rd_data = 32'd0;
    logic        irq;

    logic [31:0] bank_word = 32'd0;
    int          tests = 0;
    int          fails = 0;

    mr_pctr_ctrl #(.NUM_CTRS(64)) dut (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .ctr_en(ctr_en), .ctr_clr(ctr_clr), .ctr_sat(ctr_sat),
        .ctr_rd_req(ctr_rd_req), .ctr_rd_idx(ctr_rd_idx),
        .ctr_rd_data(ctr_rd_data), .irq(irq)
    );

    always #5 clk = ~clk;

    // Bank returns bank_word the cycle after a read request.
    always @(posedge clk)
        ctr_rd_data <= ctr_rd_req ? bank_word : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d,
                            output int waits, output int reqs, output logic [6:0] idx);
        int  n;
        bit  done;
        d = 32'hXXXX_XXXX; waits = 0; reqs = 0; idx = 7'h7F; done = 1'b0; n = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        while (!done && n < 8) begin
            @(negedge clk);
            if (ctr_rd_req === 1'b1) begin
                reqs++;
                idx = ctr_rd_idx;
            end
            if (pready === 1'b1) begin
                d = prdata;
                done = 1'b1;
            end else begin
                waits++;
            end
            n++;
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        if (!done) chk("read_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int          w, rq, n;
        logic [6:0]  ix;

        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctr_en", {31'd0, ctr_en}, 32'd0);
        chk("rst_ctr_clr", {31'd0, ctr_clr}, 32'd0);
        chk("rst_rd_req", {31'd0, ctr_rd_req}, 32'd0);
        chk("rst_rd_idx", {25'd0, ctr_rd_idx}, 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_pready", {31'd0, pready}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        apb_read(12'h000, rd, w, rq, ix); chk("ctrl_init", rd, 32'd0);
        apb_read(12'h004, rd, w, rq, ix); chk("status_init", rd, 32'd0);

        // Window of 5 cycles
        apb_write(12'h008, 32'd5);
        apb_read(12'h008, rd, w, rq, ix); chk("window_rb", rd, 32'd5);
        chk("window_rb_waits", w, 32'd0);
        apb_write(12'h000, 32'h1);
        n = 0;
        @(negedge clk);
        while (ctr_en === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        chk("win_en_cycles", n, 32'd5);
        apb_read(12'h004, rd, w, rq, ix); chk("win_status", rd, 32'h4);
        apb_read(12'h00C, rd, w, rq, ix); chk("win_wrem", rd, 32'd0);
        apb_read(12'h000, rd, w, rq, ix); chk("win_ctrl", rd, 32'd0);

        // Counter readback
        bank_word = 32'hDEADBEEF;
        apb_read(12'h11C, rd, w, rq, ix);
        chk("ctr7_data", rd, 32'hDEADBEEF);
        chk("ctr7_waits", w, 32'd1);
        chk("ctr7_reqs", rq, 32'd1);
        chk("ctr7_idx", {25'd0, ix}, 32'd7);
        @(negedge clk);
        chk("ctr7_req_low", {31'd0, ctr_rd_req}, 32'd0);
        chk("ctr7_idx_hold", {25'd0, ctr_rd_idx}, 32'd7);
        @(posedge clk); #1;
        bank_word = 32'h12345678;
        apb_read(12'h200, rd, w, rq, ix);
        chk("cyc_data", rd, 32'h12345678);
        chk("cyc_idx", {25'd0, ix}, 32'd64);
        apb_read(12'h204, rd, w, rq, ix);
        chk("beyond_data", rd, 32'd0);
        chk("beyond_waits", w, 32'd0);

        // Clear pulse with unlimited window
        apb_write(12'h008, 32'd0);
        apb_write(12'h004, 32'h4);
        apb_write(12'h000, 32'h101);
        @(negedge clk);
        chk("clr_pulse", {31'd0, ctr_clr}, 32'd1);
        chk("clr_en", {31'd0, ctr_en}, 32'd1);
        @(negedge clk);
        chk("clr_pulse_end", {31'd0, ctr_clr}, 32'd0);
        @(posedge clk); #1;
        apb_write(12'h300, 32'hFFFF_FFFF);
        apb_read(12'h300, rd, w, rq, ix);
        chk("unmapped_data", rd, 32'd0);
        chk("unmapped_waits", w, 32'd0);
        apb_read(12'h000, rd, w, rq, ix); chk("ctrl_clr_reads0", rd, 32'h1);
        repeat (3) @(posedge clk); #1;
        apb_read(12'h00C, rd, w, rq, ix); chk("unlim_wrem", rd, 32'd0);
        chk("unlim_en", {31'd0, ctr_en}, 32'd1);

        // Freeze on saturation
        apb_write(12'h000, 32'h7);
        ctr_sat = 1'b1;
        @(posedge clk); #1 ctr_sat = 1'b0;
        @(negedge clk);
        chk("sat_en_drop", {31'd0, ctr_en}, 32'd0);
        @(posedge clk); #1;
        apb_read(12'h004, rd, w, rq, ix); chk("sat_status", rd, 32'h2);
        chk("sat_irq", {31'd0, irq}, 32'd1);
        apb_write(12'h004, 32'h2);
        chk("sat_w1c_irq", {31'd0, irq}, 32'd0);

        // Saturation ignored without freeze
        apb_write(12'h000, 32'h5);
        ctr_sat = 1'b1;
        @(posedge clk); #1 ctr_sat = 1'b0;
        @(negedge clk);
        chk("nofos_en", {31'd0, ctr_en}, 32'd1);
        @(posedge clk); #1;
        apb_read(12'h004, rd, w, rq, ix); chk("nofos_status", rd, 32'h1);
        apb_write(12'h000, 32'h0);

        // W1C of WIN_DONE lands on the expiry edge
        apb_write(12'h008, 32'd2);
        apb_write(12'h000, 32'h1);
        apb_write(12'h004, 32'h4);
        apb_read(12'h004, rd, w, rq, ix); chk("w1c_vs_expiry", rd, 32'h4);

        // EN=1 write lands on the expiry edge
        apb_write(12'h004, 32'h4);
        apb_write(12'h000, 32'h1);
        apb_write(12'h000, 32'h1);
        @(negedge clk);
        chk("enwr_vs_expiry", {31'd0, ctr_en}, 32'd0);
        @(posedge clk); #1;
        apb_read(12'h000, rd, w, rq, ix); chk("enwr_vs_expiry_ctrl", rd, 32'd0);

        // Reset while waiting on a counter read
        apb_write(12'h000, 32'h4);
        bank_word = 32'hCAFEF00D;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h104;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk);
        chk("rdw_pready_low", {31'd0, pready}, 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk("rdw_rst_pready", {31'd0, pready}, 32'd1);
        chk("rdw_rst_prdata", prdata, 32'd0);
        chk("rdw_rst_req", {31'd0, ctr_rd_req}, 32'd0);
        chk("rdw_rst_idx", {25'd0, ctr_rd_idx}, 32'd0);
        chk("rdw_rst_en", {31'd0, ctr_en}, 32'd0);
        chk("rdw_rst_clr", {31'd0, ctr_clr}, 32'd0);
        chk("rdw_rst_irq", {31'd0, irq}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        apb_read(12'h000, rd, w, rq, ix); chk("post_rst_ctrl", rd, 32'd0);
        apb_read(12'h104, rd, w, rq, ix);
        chk("post_rst_ctr_data", rd, 32'hCAFEF00D);
        chk("post_rst_ctr_waits", w, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
